// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with press/release debouncing.
// Rows are driven low one at a time; columns come back through a two-flop
// synchroniser. A detected key is debounced on its own row/column before it is
// accepted. It is then held until a debounced release. Other keys pressed while
// one is held are ignored.
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_out,
  output logic       pressed,
  output logic       key_event
);

  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ridx_reg, ridx_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [DB_W-1:0]  db_reg, db_next;
  logic [1:0]       crow_reg, crow_next;
  logic [1:0]       ccol_reg, ccol_next;
  logic [3:0]       row_reg, row_next;
  logic [3:0]       key_out_reg, key_out_next;
  logic             pressed_reg, pressed_next;
  logic             key_event_reg, key_event_next;

  logic [3:0]       cs;
  logic [1:0]       cidx;
  logic             any_low;
  logic             cs_sel;

  // Two-flop synchroniser per column; idles high like the pulled-up pins.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Capture the asynchronous column and re-time it once more.
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= col[gi];
          sync_reg <= meta_reg;
        end
      end
      assign cs[gi] = sync_reg;
    end
  endgenerate

  // Lowest-index low column wins when several columns are low.
  always_comb begin
    cidx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cs[i]) cidx = 2'(i);
    end
  end

  assign any_low = ~&cs;
  assign cs_sel  = cs[ccol_reg];

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SCAN;
      ridx_reg      <= 2'd0;
      div_reg       <= '0;
      db_reg        <= '0;
      crow_reg      <= 2'd0;
      ccol_reg      <= 2'd0;
      row_reg       <= 4'b1110;
      key_out_reg   <= 4'd0;
      pressed_reg   <= 1'b0;
      key_event_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ridx_reg      <= ridx_next;
      div_reg       <= div_next;
      db_reg        <= db_next;
      crow_reg      <= crow_next;
      ccol_reg      <= ccol_next;
      row_reg       <= row_next;
      key_out_reg   <= key_out_next;
      pressed_reg   <= pressed_next;
      key_event_reg <= key_event_next;
    end
  end

  // Next-state logic: scan, debounce press, hold, debounce release.
  always_comb begin
    state_next     = state_reg;
    ridx_next      = ridx_reg;
    div_next       = div_reg;
    db_next        = db_reg;
    crow_next      = crow_reg;
    ccol_next      = ccol_reg;
    key_out_next   = key_out_reg;
    pressed_next   = pressed_reg;
    key_event_next = 1'b0;

    case (state_reg)
      SCAN: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (any_low) begin
            crow_next  = ridx_reg;
            ccol_next  = cidx;
            db_next    = '0;
            state_next = DEBOUNCE;
          end else begin
            ridx_next = ridx_reg + 2'd1;
          end
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end

      DEBOUNCE: begin
        if (!cs_sel) begin
          if (db_reg == DB_LAST) begin
            key_out_next   = {crow_reg, ccol_reg};
            pressed_next   = 1'b1;
            key_event_next = 1'b1;
            state_next     = HOLD;
          end else begin
            db_next = db_reg + DB_W'(1);
          end
        end else begin
          // Bounce: go back and let the same row settle again.
          ridx_next  = crow_reg;
          div_next   = '0;
          state_next = SCAN;
        end
      end

      HOLD: begin
        if (cs_sel) begin
          db_next    = '0;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        if (cs_sel) begin
          if (db_reg == DB_LAST) begin
            pressed_next = 1'b0;
            ridx_next    = crow_reg + 2'd1;
            div_next     = '0;
            state_next   = SCAN;
          end else begin
            db_next = db_reg + DB_W'(1);
          end
        end else begin
          state_next = HOLD;
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // Row drive follows the row the next state will be looking at.
  always_comb begin
    row_next = row_reg;
    if (state_next == SCAN) begin
      row_next = ~(4'b0001 << ridx_next);
    end else begin
      row_next = ~(4'b0001 << crow_next);
    end
  end

  assign row       = row_reg;
  assign key_out   = key_out_reg;
  assign pressed   = pressed_reg;
  assign key_event = key_event_reg;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model pulls a column low while its
// row is driven low and the key is closed. Expected key codes are queued as
// presses are issued; a monitor pops one per key_event.
module tb_keypad_scan_debounce;

  logic        clk;
  logic        rst;
  logic [3:0]  col_drv;
  logic [3:0]  row;
  logic [3:0]  key_out;
  logic        pressed;
  logic        key_event;
  logic [15:0] keys;

  int          n_checks;
  int          n_errors;
  int          ev_count;
  logic [3:0]  exp_q[$];

  keypad_scan_debounce #(
    .SCAN_DIV(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .col(col_drv),
    .row(row),
    .key_out(key_out),
    .pressed(pressed),
    .key_event(key_event)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: closed key connects its row line to its column line.
  always_comb begin
    col_drv = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col_drv[c] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Wait until pressed reaches lvl; n is the index of the edge (0 = first edge
  // after the call) that produced it, or -1 on timeout.
  task automatic wait_level(input logic lvl, input int budget, input string name, output int n);
    n = -1;
    for (int i = 0; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (pressed === lvl) begin
        n = i;
        break;
      end
    end
    check(name, 32'(n >= 0), 32'd1);
  endtask

  // Monitor: every key_event pops one expected code.
  initial begin
    logic       prev_event;
    logic [3:0] exp_code;
    prev_event = 1'b0;
    ev_count   = 0;
    forever begin
      @(negedge clk);
      if (key_event === 1'b1) begin
        ev_count++;
        $display("event #%0d key_out=%h pressed=%b", ev_count, key_out, pressed);
        check("event_not_consecutive", 32'(prev_event), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event actual=%h required=none", key_out);
        end else begin
          exp_code = exp_q.pop_front();
          check("event_key_out", 32'(key_out), 32'(exp_code));
          check("event_pressed", 32'(pressed), 32'd1);
        end
      end
      prev_event = key_event;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    int         found;
    logic [3:0] one;
    logic [3:0] exp_row;
    n_checks = 0;
    n_errors = 0;
    one      = 4'b0001;
    keys     = '0;
    rst      = 1'b1;

    // Reset and idle scan.
    repeat (3) @(negedge clk);
    check("reset_row", 32'(row), 32'hE);
    check("reset_key_out", 32'(key_out), 32'h0);
    check("reset_pressed", 32'(pressed), 32'd0);
    check("reset_key_event", 32'(key_event), 32'd0);
    rst = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_row = ~(one << ((i / 4) % 4));
      check("scan_row", 32'(row), 32'(exp_row));
    end
    check("idle_pressed", 32'(pressed), 32'd0);
    $display("idle scan done");

    // Press row2/col1.
    exp_q.push_back(4'h9);
    keys[9] = 1'b1;
    wait_level(1'b1, 27, "press9_seen", n);
    $display("press 9 accepted after %0d edges", n);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("held_row", 32'(row), 32'hB);
    end
    check("held_events", 32'(ev_count), 32'd1);
    check("held_key_out", 32'(key_out), 32'h9);

    // Release: edge 0 samples the open column, 2 sync + 8 debounce later it drops.
    keys[9] = 1'b0;
    wait_level(1'b0, 12, "release9_seen", n);
    check("release9_latency", 32'(n), 32'd10);
    check("release_key_out", 32'(key_out), 32'h9);
    check("resume_row", 32'(row), 32'h7);
    $display("release 9 after %0d edges", n);

    // Bounce row0/col3, never stable for 8 cycles.
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      keys[3] = ((k / 3) % 2 == 0);
      @(negedge clk);
    end
    check("bounce_no_event", 32'(ev_count), 32'd1);
    check("bounce_pressed", 32'(pressed), 32'd0);
    exp_q.push_back(4'h3);
    keys[3] = 1'b1;
    wait_level(1'b1, 27, "press3_seen", n);
    repeat (12) @(negedge clk);
    check("press3_events", 32'(ev_count), 32'd2);
    check("press3_key_out", 32'(key_out), 32'h3);
    keys[3] = 1'b0;
    wait_level(1'b0, 12, "release3_seen", n);
    check("release3_latency", 32'(n), 32'd10);
    $display("bounce press 3 handled");

    // Two keys on row1, pressed once scanning is back at row0.
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (row === 4'hE) begin
        found = 1;
        break;
      end
    end
    check("row0_reached", 32'(found), 32'd1);
    exp_q.push_back(4'h4);
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    wait_level(1'b1, 27, "press4_seen", n);
    keys[15] = 1'b1;
    repeat (40) @(negedge clk);
    check("no_rollover_events", 32'(ev_count), 32'd3);
    check("no_rollover_key_out", 32'(key_out), 32'h4);
    check("no_rollover_pressed", 32'(pressed), 32'd1);
    check("no_rollover_row", 32'(row), 32'hD);
    $display("simultaneous press 4 held, 15 ignored");

    // Reset while held; keys stay closed and are found again.
    rst = 1'b1;
    @(negedge clk);
    check("midrst_row", 32'(row), 32'hE);
    check("midrst_pressed", 32'(pressed), 32'd0);
    check("midrst_key_out", 32'(key_out), 32'h0);
    check("midrst_key_event", 32'(key_event), 32'd0);
    exp_q.push_back(4'h4);
    rst = 1'b0;
    wait_level(1'b1, 27, "repress4_seen", n);
    repeat (5) @(negedge clk);
    check("final_events", 32'(ev_count), 32'd4);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("reset re-detect done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
